// File: rtl/mld_7_3_decoder_if.sv
// Handshake bundle for the (7,3) majority-logic decoder: word in, corrected word and status out.
// The master side is upstream/sink logic and the slave side is the decoder.
interface mld_7_3_decoder_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       cw_in;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       cw_out;
    logic [2:0]       info_out;
    logic             out_valid;
    logic             out_ready;
    logic             corrected;
    logic [CNT_W-1:0] err_count;
    logic [2:0]       corr_cnt;
    logic             uncorrectable;

    modport master (
        output cw_in, in_valid, out_ready,
        input  in_ready, cw_out, info_out, out_valid, corrected, err_count, corr_cnt, uncorrectable
    );

    modport slave (
        input  cw_in, in_valid, out_ready,
        output in_ready, cw_out, info_out, out_valid, corrected, err_count, corr_cnt, uncorrectable
    );
endinterface

// File: rtl/mld_7_3_decoder.sv
// Serial one-step majority-logic decoder for the (7,3) cyclic code, g(x) = 1 + x^2 + x^3 + x^4.
// Optional feature macro MLD_MULTI_ERR_FLAG_EN enables the per-word correction tally outputs.
module mld_7_3_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    mld_7_3_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;

    state_t           state;
    logic [6:0]       shift_q;
    logic [2:0]       cnt;
    logic             any_flip;
    logic [6:0]       cw_q;
    logic             corrected_q;
    logic [CNT_W-1:0] err_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             a1, a2, a3, e;
    logic [6:0]       shift_next;
    logic             flip_next;

    // Three checks orthogonal on the bit currently in position 6; the majority decides the flip.
    always_comb begin
        a1         = shift_q[3] ^ shift_q[4] ^ shift_q[6];
        a2         = shift_q[1] ^ shift_q[5] ^ shift_q[6];
        a3         = shift_q[0] ^ shift_q[2] ^ shift_q[6];
        e          = (a1 & a2) | (a1 & a3) | (a2 & a3);
        shift_next = {shift_q[5:0], shift_q[6] ^ e};
        flip_next  = any_flip | e;
    end

`ifdef MLD_MULTI_ERR_FLAG_EN
    logic [2:0] tally;
    logic [2:0] tally_next;
    logic [2:0] corr_q;
    logic       uncorr_q;

    always_comb begin
        tally_next = (tally == 3'd7) ? tally : tally + {2'b00, e};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tally    <= 3'd0;
            corr_q   <= 3'd0;
            uncorr_q <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.in_valid && in_ready_q) begin
                tally <= 3'd0;
            end
        end else if (state == DECODE) begin
            tally <= tally_next;
            if (cnt == 3'd6) begin
                corr_q   <= tally_next;
                uncorr_q <= (tally_next > 3'd1);
            end
        end
    end

    assign bus.corr_cnt      = corr_q;
    assign bus.uncorrectable = uncorr_q;
`else
    assign bus.corr_cnt      = 3'd0;
    assign bus.uncorrectable = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_q     <= 7'd0;
            cnt         <= 3'd0;
            any_flip    <= 1'b0;
            cw_q        <= 7'd0;
            corrected_q <= 1'b0;
            err_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        shift_q    <= bus.cw_in;
                        cnt        <= 3'd0;
                        any_flip   <= 1'b0;
                        in_ready_q <= 1'b0;
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    shift_q  <= shift_next;
                    any_flip <= flip_next;
                    cnt      <= cnt + 3'd1;
                    // Seventh shift restores the original alignment, so the result is final here.
                    if (cnt == 3'd6) begin
                        cw_q        <= shift_next;
                        corrected_q <= flip_next;
                        out_valid_q <= 1'b1;
                        state       <= OUT;
                        if (flip_next && (err_q != '1)) begin
                            err_q <= err_q + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cw_out    = cw_q;
    assign bus.info_out  = cw_q[6:4];
    assign bus.corrected = corrected_q;
    assign bus.err_count = err_q;

endmodule

// File: doc/mld_7_3_decoder.md
Name: mld_7_3_decoder

Overview:
- One-step majority-logic decoder for the (7,3) cyclic code with g(x) = 1 + x^2 + x^3 + x^4.
- Consumes codewords whose systematic parity the upstream LFSR encoder produces.
- Each accepted 7-bit word is decoded serially by cyclic shifting. The corrected codeword, the message bits and status are returned through a valid/ready handshake.
- Sits directly downstream of the encoder/channel model, in front of the test sink.

Parameters:
CNT_W, 16, width of the saturating corrected-word statistics counter (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cw_in  input  7  received word; bit i = coefficient of x^i; [3:0] parity r0..r3, [6:4] message (first message bit fed to the encoder is at bit 6)
in_valid  input  1  cw_in valid
in_ready  output  1  decoder can accept a word
cw_out  output  7  corrected codeword, same bit layout as cw_in
info_out  output  3  cw_out[6:4]
out_valid  output  1  cw_out/info_out/status valid
out_ready  input  1  sink accepts result
corrected  output  1  at least one bit was flipped for this word
err_count  output  CNT_W  number of words with corrected=1, saturating
corr_cnt  output  3  corrections applied to this word (optional feature)
uncorrectable  output  1  more than one correction applied (optional feature)

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-decode):
  - state=IDLE, buffer=0, cycle count=0.
  - in_ready=1, out_valid=0, cw_out=0, corrected=0, err_count=0, corr_cnt=0, uncorrectable=0.
  - Any in-flight word is discarded.
- FSM states: IDLE, DECODE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: buffer b<=cw_in, cnt<=0, correction tally<=0, state<=DECODE.
- DECODE (7 cycles, cnt 0..6, in_ready=0):
  - Orthogonal checks on b6: A1=b3^b4^b6, A2=b1^b5^b6, A3=b0^b2^b6.
  - e = majority(A1,A2,A3), i.e. at least 2 of 3 checks set.
  - Cyclic shift: b[j]<=b[j-1] for j=1..6, b[0]<=b6^e.
  - Tally increments when e=1; it saturates at 7.
  - At cnt==6 the buffer is back in original alignment; state<=OUT.
  - Result registers load on this edge: cw_out, corrected=(tally!=0), corr_cnt.
  - err_count increments on this same edge if corrected=1, holding at all-ones.
- OUT:
  - out_valid=1; outputs are stable while out_ready=0.
  - On out_ready: out_valid<=0, state<=IDLE.
  - in_ready rises the cycle after the output handshake. There is no overlap, so minimum throughput is 1 word per 9 cycles.
- Latency: the word is accepted at edge E0. Shifts occur on E1..E7 and out_valid is high from E7.
- cw_out and the status outputs hold their last values while in IDLE/DECODE. Only out_valid qualifies them.
- Error handling:
  - Any single-bit error is always corrected.
  - Two or more errors may be miscorrected to a different codeword; the base block does not flag this.
- in_valid is ignored in DECODE/OUT; the upstream must hold the word until in_ready.

Optional Feature:
MLD_MULTI_ERR_FLAG_EN
- Defined:
  - corr_cnt reports the saturating count of corrections applied to the word.
  - uncorrectable = (corr_cnt>1), because this code corrects at most one error.
  - Both outputs load with cw_out and reset to 0.
- Undefined:
  - The ports remain; corr_cnt and uncorrectable are tied to 0 and the tally logic is not synthesised.
  - All other behaviour is identical.

Test Plan:
- Clean words: 7'h4E, 7'h27, 7'h1D, 7'h74 in turn -> cw_out unchanged, info_out=100/010/001/111, corrected=0, err_count stays 0, out_valid exactly 7 cycles after each accepting edge.
- Single-error sweep: 7'h74 with each bit i=0..6 flipped (e.g. 7'h34, 7'h75) -> cw_out=7'h74, info_out=3'b111, corrected=1, corr_cnt=1, uncorrectable=0; err_count=7 afterwards.
- Double error: 7'h4D (7'h4E with bits 1,0 flipped) -> cw_out=7'h1D, corrected=1; with MLD_MULTI_ERR_FLAG_EN, corr_cnt=2 and uncorrectable=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is not accepted; in_ready=1 the cycle after out_ready.
- Saturation with CNT_W=2: 5 consecutive single-error words -> err_count 1,2,3,3,3.
- Reset at DECODE cnt==3 -> next cycle in_ready=1, out_valid=0, err_count=0; the next word 7'h27 decodes normally.
